clock12_ctrl: RTL and testbench

Timekeeping controller that sequences a mod-12 hour counter together with mod-60 minute and second counters into a 12-hour clock with AM/PM. A clock-enable prescaler derives the one-second tick. A three-state set-mode FSM lets the user adjust hours and minutes from two button pulses. It sits between the board button conditioning logic and the display driver, and is the sole owner of the hour counter's enable and load.

---
 rtl/clock12_pkg.sv | 15 +
 rtl/modn_counter.sv | 42 ++++
 rtl/clock12_ctrl.sv | 110 +++++++++++
 tb/tb_clock12_ctrl.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clock12_pkg.sv
// Shared definitions for the 12-hour clock controller: set-mode state
// encoding and the moduli of the time fields.
package clock12_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_SET_HR  = 2'd1,
        ST_SET_MIN = 2'd2
    } state_t;

    localparam int unsigned SEC_MOD  = 60;
    localparam int unsigned MIN_MOD  = 60;
    localparam int unsigned HOUR_MOD = 12;

endpackage

// File: rtl/modn_counter.sv
// Modulo-N counter with synchronous clear and a combinational carry that
// flags the enabled wrap from N-1 back to 0.
module modn_counter #(
    parameter int unsigned N = 60,
    parameter int unsigned W = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] count,
    output logic         carry
);

    localparam logic [W-1:0] LAST = W'(N - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear dominates, otherwise step with wrap when enabled.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == LAST) ? '0 : count_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign carry = en && (count_q == LAST);

endmodule

// File: rtl/clock12_ctrl.sv
// 12-hour clock controller: one-second prescaler, sec/min/hour carry chain
// with AM/PM, and a RUN -> SET_HR -> SET_MIN set-mode FSM.
module clock12_ctrl
    import clock12_pkg::*;
#(
    parameter int unsigned TICK_DIV = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       run_en,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic [5:0] sec,
    output logic [5:0] min,
    output logic [3:0] hour,
    output logic       pm,
    output logic       sec_tick,
    output logic [1:0] state
);

    localparam int unsigned   PW         = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_t        state_q;
    logic [PW-1:0] presc_q;
    logic          sec_tick_q;
    logic          pm_q;

    logic in_run, in_set_hr, in_set_min;
    logic tick, hr_inc, min_inc, sec_clr;
    logic min_en, hour_en;
    logic sec_carry, min_carry, hour_carry;

    assign in_run     = (state_q == ST_RUN);
    assign in_set_hr  = (state_q == ST_SET_HR);
    assign in_set_min = (state_q == ST_SET_MIN);

    // A mode press always wins: it blocks the tick and drops any inc press.
    assign tick    = in_run && run_en && !mode_btn && (presc_q == PRESC_LAST);
    assign hr_inc  = in_set_hr  && inc_btn && !mode_btn;
    assign min_inc = in_set_min && inc_btn && !mode_btn;
    assign sec_clr = in_set_min && mode_btn;

    // Manual minute steps may wrap 59->0 but must never carry into the hour,
    // so the hour only sees the minute carry when seconds also carried.
    assign min_en  = sec_carry | min_inc;
    assign hour_en = (sec_carry && min_carry) | hr_inc;

    modn_counter #(.N(SEC_MOD), .W(6)) u_sec (
        .clk   (clk),
        .reset (reset),
        .en    (tick),
        .clr   (sec_clr),
        .count (sec),
        .carry (sec_carry)
    );

    modn_counter #(.N(MIN_MOD), .W(6)) u_min (
        .clk   (clk),
        .reset (reset),
        .en    (min_en),
        .clr   (1'b0),
        .count (min),
        .carry (min_carry)
    );

    modn_counter #(.N(HOUR_MOD), .W(4)) u_hour (
        .clk   (clk),
        .reset (reset),
        .en    (hour_en),
        .clr   (1'b0),
        .count (hour),
        .carry (hour_carry)
    );

    // Set-mode FSM, prescaler and registered second tick.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_RUN;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            sec_tick_q <= tick;
            if (mode_btn) begin
                unique case (state_q)
                    ST_RUN:    state_q <= ST_SET_HR;
                    ST_SET_HR: state_q <= ST_SET_MIN;
                    default:   state_q <= ST_RUN;
                endcase
                presc_q <= '0;
            end else if (in_run && run_en) begin
                presc_q <= (presc_q == PRESC_LAST) ? '0 : presc_q + PW'(1);
            end
        end
    end

    // AM/PM flips on every hour wrap 11 -> 0, whether counted or set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pm_q <= 1'b0;
        end else if (hour_carry) begin
            pm_q <= ~pm_q;
        end
    end

    assign pm       = pm_q;
    assign sec_tick = sec_tick_q;
    assign state    = state_q;

endmodule

// File: tb/tb_clock12_ctrl.sv
// Self-checking bench for clock12_ctrl with TICK_DIV = 4. The reference model
// keeps time as seconds since midnight and derives every field from it.
module tb_clock12_ctrl;

    localparam int TD  = 4;
    localparam int DAY = 86400;

    logic       clk;
    logic       reset;
    logic       run_en;
    logic       mode_btn;
    logic       inc_btn;
    logic [5:0] sec;
    logic [5:0] min;
    logic [3:0] hour;
    logic       pm;
    logic       sec_tick;
    logic [1:0] state;

    clock12_ctrl #(.TICK_DIV(TD)) dut (
        .clk      (clk),
        .reset    (reset),
        .run_en   (run_en),
        .mode_btn (mode_btn),
        .inc_btn  (inc_btn),
        .sec      (sec),
        .min      (min),
        .hour     (hour),
        .pm       (pm),
        .sec_tick (sec_tick),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: time of day in seconds, enabled-cycle phase, mode 0/1/2.
    int t      = 0;
    int ph     = 0;
    int mstate = 0;
    int m_tick = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        t = 0; ph = 0; mstate = 0; m_tick = 0;
    endtask

    task automatic model_edge(input logic m, input logic i, input logic r);
        m_tick = 0;
        if (m) begin
            if (mstate == 0) ph = 0;
            if (mstate == 2) begin
                ph = 0;
                t  = t - (t % 60);
            end
            mstate = (mstate + 1) % 3;
        end else if (mstate == 0) begin
            if (r) begin
                ph++;
                if (ph == TD) begin
                    ph     = 0;
                    t      = (t + 1) % DAY;
                    m_tick = 1;
                end
            end
        end else if (mstate == 1) begin
            if (i) t = (t + 3600) % DAY;
        end else begin
            if (i) begin
                if ((t / 60) % 60 == 59) t = t - 59 * 60;
                else                     t = t + 60;
            end
        end
    endtask

    task automatic check_model();
        chk("sec",   32'(sec),      32'(t % 60));
        chk("min",   32'(min),      32'((t / 60) % 60));
        chk("hour",  32'(hour),     32'((t / 3600) % 12));
        chk("pm",    32'(pm),       32'((t / 43200) % 2));
        chk("tick",  32'(sec_tick), 32'(m_tick));
        chk("state", 32'(state),    32'(mstate));
    endtask

    // One clock cycle: drive inputs, let the edge happen, compare after it.
    task automatic step(input logic m, input logic i, input logic r);
        mode_btn = m;
        inc_btn  = i;
        run_en   = r;
        @(posedge clk);
        model_edge(m, i, r);
        #1;
        check_model();
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_sec"},   32'(sec),      32'd0);
        chk({tag, "_min"},   32'(min),      32'd0);
        chk({tag, "_hour"},  32'(hour),     32'd0);
        chk({tag, "_pm"},    32'(pm),       32'd0);
        chk({tag, "_tick"},  32'(sec_tick), 32'd0);
        chk({tag, "_state"}, 32'(state),    32'd0);
    endtask

    initial begin
        reset    = 1'b1;
        run_en   = 1'b0;
        mode_btn = 1'b0;
        inc_btn  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        reset = 1'b0;

        // Reset: run, then reset in mid-cycle and observe before the next edge.
        for (int k = 0; k < 30; k++) step(1'b0, 1'b0, 1'b1);
        reset = 1'b1;
        #2;
        check_zero("midrst");
        model_reset();
        #2;
        reset = 1'b0;

        // Tick cadence: ticks at cycles 4, 8, 12 only.
        for (int k = 1; k <= 12; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("cad_tick", 32'(sec_tick), 32'((k % 4 == 0) ? 1 : 0));
        end
        chk("cad_sec", 32'(sec), 32'd3);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b0, 1'b0);
        chk("hold_sec", 32'(sec), 32'd3);

        // Hour set with wrap: 13 presses from 12 AM give 1 PM.
        step(1'b1, 1'b0, 1'b1);
        chk("sethr_state", 32'(state), 32'd1);
        for (int k = 0; k < 13; k++) step(1'b0, 1'b1, 1'b1);
        chk("sethr_hour", 32'(hour), 32'd1);
        chk("sethr_pm",   32'(pm),   32'd1);
        chk("sethr_sec",  32'(sec),  32'd3);

        // Minute set: 61 presses give min 1, no hour carry; exit clears sec.
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 61; k++) step(1'b0, 1'b1, 1'b1);
        chk("setmin_min",  32'(min),  32'd1);
        chk("setmin_hour", 32'(hour), 32'd1);
        step(1'b1, 1'b0, 1'b1);
        chk("exit_state", 32'(state), 32'd0);
        chk("exit_sec",   32'(sec),   32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 1'b1);
            chk("exit_tick", 32'(sec_tick), 32'((k == 4) ? 1 : 0));
        end

        // Full rollover from 11:59:00 PM.
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 58; k++) step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("pre_roll_hour", 32'(hour), 32'd11);
        chk("pre_roll_min",  32'(min),  32'd59);
        chk("pre_roll_pm",   32'(pm),   32'd1);
        for (int k = 0; k < 60 * TD; k++) step(1'b0, 1'b0, 1'b1);
        chk("roll_sec",  32'(sec),  32'd0);
        chk("roll_min",  32'(min),  32'd0);
        chk("roll_hour", 32'(hour), 32'd0);
        chk("roll_pm",   32'(pm),   32'd0);

        // Priority: mode and inc together change state only.
        step(1'b1, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) step(1'b0, 1'b1, 1'b1);
        chk("prio_pre_hour", 32'(hour), 32'd5);
        step(1'b1, 1'b1, 1'b1);
        chk("prio_state", 32'(state), 32'd2);
        chk("prio_hour",  32'(hour),  32'd5);
        step(1'b1, 1'b0, 1'b1);

        // Randomized traffic against the model.
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 2) == 0)  ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0)  ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
